dmem_access_ctrl: RTL and testbench
===================================

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the max ACCESS-state wait cycles before fault; used only when the timeout feature is compiled in.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 MemWriteM  input  1  M-stage store flag from the execute/memory pipeline register.
REQ-005 ResultSrcM  input  2  M-stage result select; 2'b01 SHALL mean load.
REQ-006 ALUResultM  input  32  effective address.
REQ-007 WriteDataM  input  32  store data.
REQ-008 mem_ready  input  1  data memory acknowledge; sampled only in ACCESS.
REQ-009 mem_rdata  input  32  data memory read data, valid with mem_ready.
REQ-010 mem_req  output  1  registered request to data memory.
REQ-011 mem_we  output  1  registered write enable, valid with mem_req.
REQ-012 mem_addr, mem_wdata  output  32 each  registered address/data, stable while mem_req=1.
REQ-013 ReadDataM  output  32  captured load data.
REQ-014 StallPipe  output  1  freezes F/D/E/M pipeline registers.
REQ-015 MemFault  output  1  sticky timeout flag.

Function
REQ-016 Access SHALL be defined as MemWriteM=1 or ResultSrcM=2'b01.
REQ-017 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-018 IDLE + access: latch ALUResultM, WriteDataM, MemWriteM into mem_addr/mem_wdata/mem_we; set mem_req=1; go ACCESS.
REQ-019 IDLE + no access: stay IDLE; mem_req=0.
REQ-020 ACCESS + mem_ready=1: mem_req=0; for loads capture mem_rdata into ReadDataM; go DONE.
REQ-021 ACCESS + mem_ready=0: hold mem_req, mem_we, mem_addr, mem_wdata unchanged; stay ACCESS.
REQ-022 DONE: go IDLE unconditionally; access inputs SHALL NOT be re-detected in DONE.
REQ-023 StallPipe SHALL be combinational: 1 when (IDLE and access) or ACCESS; else 0.
REQ-024 With ack in the first ACCESS cycle, an access SHALL stall exactly 2 cycles; each extra wait cycle adds 1.
REQ-025 mem_ready in IDLE or DONE SHALL be ignored.
REQ-026 Stores SHALL leave ReadDataM unchanged; ReadDataM SHALL hold until the next completed load.
REQ-027 Back-to-back accesses: the next access is detected in the IDLE cycle after DONE; no idle gap is inserted beyond DONE.

Reset
REQ-028 reset=1 SHALL force state IDLE; mem_req, mem_we, MemFault = 0; mem_addr, mem_wdata, ReadDataM = 32'h0; wait counter = 0.
REQ-029 reset during ACCESS SHALL abort the access; mem_req SHALL be 0 on the following cycle; no data is captured.
REQ-030 StallPipe SHALL be 0 while reset=1.

Configuration
REQ-031 Macro DMEM_TIMEOUT_EN defined: a wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with mem_ready=0.
REQ-032 When the counter reaches TIMEOUT_CYCLES: drop mem_req, set MemFault=1 (sticky until reset), load ReadDataM=32'hDEADBEEF if a load, go DONE.
REQ-033 mem_ready=1 in the same cycle the counter reaches TIMEOUT_CYCLES SHALL complete normally with no fault.
REQ-034 Macro undefined: no counter logic; ACCESS waits indefinitely; MemFault tied 0.

Verification
REQ-035 Load with ALUResultM=0x100 and mem_ready=1 in the first ACCESS cycle -> mem_req high 1 cycle with mem_addr=0x100 and mem_we=0; StallPipe high 2 cycles; ReadDataM=mem_rdata (0xCAFEF00D).
REQ-036 Store with WriteDataM=0x12345678 and mem_ready delayed 3 cycles -> mem_we=1, mem_wdata stable for 4 cycles; StallPipe high 5 cycles; ReadDataM unchanged.
REQ-037 Load immediately followed by store -> two separate request pulses; the store is detected in the IDLE cycle after DONE.
REQ-038 reset asserted in the second ACCESS cycle -> mem_req=0 and StallPipe=0 next cycle; all outputs at reset values.
REQ-039 DMEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, mem_ready never asserted -> mem_req drops after 4 wait cycles; MemFault=1 and held; ReadDataM=0xDEADBEEF.
REQ-040 Spurious mem_ready=1 in IDLE with no access -> no state change; mem_req=0; StallPipe=0.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns M-stage load/store flags into a registered
// request handshake and stalls the pipeline until it completes. Optional macro: DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] ReadDataM,
  output logic        StallPipe,
  output logic        MemFault
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } stateT;

  stateT       stateR, stateNextS;
  logic        accessS, isLoadS, stallS;
  logic        reqR, reqNextS;
  logic        weR, weNextS;
  logic        isLoadR, isLoadNextS;
  logic [31:0] addrR, addrNextS;
  logic [31:0] wdataR, wdataNextS;
  logic [31:0] rdataR, rdataNextS;

  assign accessS = MemWriteM | (ResultSrcM == 2'b01);
  // A combined store+load encoding is treated as a store: no read data is captured.
  assign isLoadS = ~MemWriteM & (ResultSrcM == 2'b01);

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] waitCntR, waitCntNextS;
  logic             faultR, faultNextS;
  logic             timeoutS;

  // The final wait cycle is the one whose increment brings the count to the limit.
  assign timeoutS = (waitCntR == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unusedTimeoutS;
  assign unusedTimeoutS = (TIMEOUT_CYCLES == 32'sd0);
`endif

  // Next-state and next-output computation for the access FSM
  always_comb begin
    stateNextS  = stateR;
    reqNextS    = reqR;
    weNextS     = weR;
    isLoadNextS = isLoadR;
    addrNextS   = addrR;
    wdataNextS  = wdataR;
    rdataNextS  = rdataR;
    stallS      = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    waitCntNextS = waitCntR;
    faultNextS   = faultR;
`endif
    case (stateR)
      IDLE: begin
        if (accessS) begin
          stateNextS  = ACCESS;
          reqNextS    = 1'b1;
          weNextS     = MemWriteM;
          isLoadNextS = isLoadS;
          addrNextS   = ALUResultM;
          wdataNextS  = WriteDataM;
          stallS      = 1'b1;
`ifdef DMEM_TIMEOUT_EN
          waitCntNextS = '0;
`endif
        end else begin
          reqNextS = 1'b0;
        end
      end
      ACCESS: begin
        stallS = 1'b1;
        if (mem_ready) begin
          stateNextS = DONE;
          reqNextS   = 1'b0;
          weNextS    = 1'b0;
          if (isLoadR) begin
            rdataNextS = mem_rdata;
          end else begin
            rdataNextS = rdataR;
          end
        end
`ifdef DMEM_TIMEOUT_EN
        else if (timeoutS) begin
          stateNextS   = DONE;
          reqNextS     = 1'b0;
          weNextS      = 1'b0;
          faultNextS   = 1'b1;
          waitCntNextS = waitCntR + CNT_W'(1);
          if (isLoadR) begin
            rdataNextS = 32'hDEAD_BEEF;
          end else begin
            rdataNextS = rdataR;
          end
        end else begin
          waitCntNextS = waitCntR + CNT_W'(1);
        end
`else
        else begin
          stateNextS = ACCESS;
        end
`endif
      end
      DONE: begin
        stateNextS = IDLE;
        reqNextS   = 1'b0;
      end
      default: begin
        stateNextS = IDLE;
        reqNextS   = 1'b0;
        weNextS    = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR  <= IDLE;
      reqR    <= 1'b0;
      weR     <= 1'b0;
      isLoadR <= 1'b0;
      addrR   <= 32'h0;
      wdataR  <= 32'h0;
      rdataR  <= 32'h0;
    end else begin
      stateR  <= stateNextS;
      reqR    <= reqNextS;
      weR     <= weNextS;
      isLoadR <= isLoadNextS;
      addrR   <= addrNextS;
      wdataR  <= wdataNextS;
      rdataR  <= rdataNextS;
    end
  end

`ifdef DMEM_TIMEOUT_EN
  // Wait counter and sticky fault flag
  always_ff @(posedge clk) begin
    if (reset) begin
      waitCntR <= '0;
      faultR   <= 1'b0;
    end else begin
      waitCntR <= waitCntNextS;
      faultR   <= faultNextS;
    end
  end

  assign MemFault = faultR;
`else
  assign MemFault = 1'b0;
`endif

  assign StallPipe = stallS & ~reset;
  assign mem_req   = reqR;
  assign mem_we    = weR;
  assign mem_addr  = addrR;
  assign mem_wdata = wdataR;
  assign ReadDataM = rdataR;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed, table-driven bench for dmem_access_ctrl plus hand sequences for
// reset-abort and the wait/timeout behaviour.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, mem_rdata;
  logic        mem_ready;
  logic        mem_req, mem_we, StallPipe, MemFault;
  logic [31:0] mem_addr, mem_wdata, ReadDataM;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .ReadDataM(ReadDataM), .StallPipe(StallPipe), .MemFault(MemFault)
  );

  typedef struct {
    logic        mw;
    logic [1:0]  rs;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic [31:0] rdata;
    logic        eReq;
    logic        eWe;
    logic [31:0] eAddr;
    logic [31:0] eWdata;
    logic        eStall;
    logic [31:0] eRd;
  } vecT;

  vecT vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mw, input logic [1:0] rs, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdy, input logic [31:0] rd);
    MemWriteM = mw; ResultSrcM = rs; ALUResultM = a; WriteDataM = wd;
    mem_ready = rdy; mem_rdata = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // Each row is one cycle: inputs applied after posedge, outputs checked at negedge.
    //           mw    rs     addr          wdata         rdy   rdata        req   we    eAddr         eWdata        stall eRd
    vq.push_back('{1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 32'h9999_9999, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0});
    vq.push_back('{1'b0, 2'b01, 32'h100,      32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h0});
    vq.push_back('{1'b0, 2'b01, 32'h100,      32'h0,        1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h100,      32'h0,        1'b1, 32'h0});
    vq.push_back('{1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h100,      32'h0,        1'b0, 32'hCAFE_F00D});
    vq.push_back('{1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h100,      32'h0,        1'b0, 32'hCAFE_F00D});
    vq.push_back('{1'b1, 2'b00, 32'h200,      32'h1234_5678, 1'b0, 32'h0,        1'b0, 1'b0, 32'h100,      32'h0,        1'b1, 32'hCAFE_F00D});
    vq.push_back('{1'b1, 2'b00, 32'h200,      32'h1234_5678, 1'b0, 32'h0,        1'b1, 1'b1, 32'h200,      32'h1234_5678, 1'b1, 32'hCAFE_F00D});
    vq.push_back('{1'b1, 2'b00, 32'h200,      32'h1234_5678, 1'b0, 32'h0,        1'b1, 1'b1, 32'h200,      32'h1234_5678, 1'b1, 32'hCAFE_F00D});
    vq.push_back('{1'b1, 2'b00, 32'h200,      32'h1234_5678, 1'b0, 32'h0,        1'b1, 1'b1, 32'h200,      32'h1234_5678, 1'b1, 32'hCAFE_F00D});
    vq.push_back('{1'b1, 2'b00, 32'h200,      32'h1234_5678, 1'b1, 32'h5555_5555, 1'b1, 1'b1, 32'h200,      32'h1234_5678, 1'b1, 32'hCAFE_F00D});
    vq.push_back('{1'b0, 2'b01, 32'h300,      32'h0,        1'b1, 32'h7777_7777, 1'b0, 1'b0, 32'h200,      32'h1234_5678, 1'b0, 32'hCAFE_F00D});
    vq.push_back('{1'b0, 2'b01, 32'h300,      32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h200,      32'h1234_5678, 1'b1, 32'hCAFE_F00D});
    vq.push_back('{1'b0, 2'b01, 32'h300,      32'h0,        1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 32'h300,      32'h0,        1'b1, 32'hCAFE_F00D});
    vq.push_back('{1'b1, 2'b00, 32'h304,      32'hBEEF_0002, 1'b0, 32'h0,        1'b0, 1'b0, 32'h300,      32'h0,        1'b0, 32'hA5A5_0001});
    vq.push_back('{1'b1, 2'b00, 32'h304,      32'hBEEF_0002, 1'b0, 32'h0,        1'b0, 1'b0, 32'h300,      32'h0,        1'b1, 32'hA5A5_0001});
    vq.push_back('{1'b1, 2'b00, 32'h304,      32'hBEEF_0002, 1'b1, 32'h3333_3333, 1'b1, 1'b1, 32'h304,      32'hBEEF_0002, 1'b1, 32'hA5A5_0001});
    vq.push_back('{1'b0, 2'b10, 32'h0,        32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 32'h304,      32'hBEEF_0002, 1'b0, 32'hA5A5_0001});
    vq.push_back('{1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h304,      32'hBEEF_0002, 1'b0, 32'hA5A5_0001});

    // Reset with an access presented: outputs at reset values, no stall.
    reset = 1'b1;
    drive(1'b0, 2'b01, 32'h100, 32'h0, 1'b1, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_fault", {31'h0, MemFault}, 32'h0);
    chk("rst_stall", {31'h0, StallPipe}, 32'h0);
    reset = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      drive(vq[i].mw, vq[i].rs, vq[i].addr, vq[i].wdata, vq[i].rdy, vq[i].rdata);
      @(negedge clk);
      chk($sformatf("v%0d_req", i), {31'h0, mem_req}, {31'h0, vq[i].eReq});
      chk($sformatf("v%0d_we", i), {31'h0, mem_we}, {31'h0, vq[i].eWe});
      chk($sformatf("v%0d_addr", i), mem_addr, vq[i].eAddr);
      chk($sformatf("v%0d_wdata", i), mem_wdata, vq[i].eWdata);
      chk($sformatf("v%0d_stall", i), {31'h0, StallPipe}, {31'h0, vq[i].eStall});
      chk($sformatf("v%0d_rdata", i), ReadDataM, vq[i].eRd);
      chk($sformatf("v%0d_fault", i), {31'h0, MemFault}, 32'h0);
    end

    // Reset in the second ACCESS cycle aborts the load.
    @(posedge clk); #1;
    drive(1'b0, 2'b01, 32'h400, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_req1", {31'h0, mem_req}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("abort_stall_in_rst", {31'h0, StallPipe}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("abort_req", {31'h0, mem_req}, 32'h0);
    chk("abort_stall", {31'h0, StallPipe}, 32'h0);
    chk("abort_addr", mem_addr, 32'h0);
    chk("abort_rdata", ReadDataM, 32'h0);
    chk("abort_we", {31'h0, mem_we}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_idle_req", {31'h0, mem_req}, 32'h0);

    // Load with memory never acknowledging.
    @(posedge clk); #1;
    drive(1'b0, 2'b01, 32'h500, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("wait_stall0", {31'h0, StallPipe}, 32'h1);
    cnt = 0;
`ifdef DMEM_TIMEOUT_EN
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req) begin
        cnt++;
      end else begin
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        break;
      end
    end
    chk("to_req_cycles", cnt, 32'd4);
    chk("to_fault", {31'h0, MemFault}, 32'h1);
    chk("to_rdata", ReadDataM, 32'hDEAD_BEEF);
    chk("to_stall_done", {31'h0, StallPipe}, 32'h0);
    repeat (3) @(negedge clk);
    chk("to_fault_held", {31'h0, MemFault}, 32'h1);
    chk("to_req_idle", {31'h0, mem_req}, 32'h0);
`else
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_req && StallPipe) cnt++;
    end
    chk("wait_req_cycles", cnt, 32'd10);
    chk("wait_fault", {31'h0, MemFault}, 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("wait_done_req", {31'h0, mem_req}, 32'h0);
    chk("wait_rdata", ReadDataM, 32'h0BAD_F00D);
    chk("wait_fault_after", {31'h0, MemFault}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
